// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier: one partial-product row per clock, WIDTH
// rows per product, optional two's-complement operands, valid/ready on both
// the operand and the result side.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | accumulating partial products, WIDTH cycles, fixed latency
// DONE  | product presented with out_valid until out_ready
module seq_array_multiplier #(
  parameter int WIDTH          = 4,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic [PW-1:0]   product_q;

  logic            accept;
  logic            last_step;
  logic            sm_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [PW-1:0]   acc_add;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   product_final;

  // Handshake qualifiers and the magnitude/sign split of the incoming operands
  always_comb begin
    accept    = in_valid && (state_q == S_IDLE);
    last_step = (state_q == S_CALC) && (cnt_q == '0);
    sm_in     = SIGNED_SUPPORT ? signed_mode : 1'b0;
    a_neg_in  = sm_in & a[WIDTH-1];
    b_neg_in  = sm_in & b[WIDTH-1];
    // The most negative value negates onto itself, which read as unsigned is
    // exactly 2^(WIDTH-1): the correct magnitude, so no special case needed.
    a_mag_in  = a_neg_in ? -a : a;
    b_mag_in  = b_neg_in ? -b : b;
  end

  // One partial-product row per cycle; the adder is unsigned and wide enough
  // that it never overflows, the sign is applied once at the end
  always_comb begin
    acc_add       = mplier_q[0] ? mcand_q : '0;
    acc_sum       = acc_q + acc_add;
    product_final = neg_q ? -acc_sum : acc_sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)    state_d = S_CALC;
      S_CALC: if (last_step) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Output decode; rst masks in_ready so a source never sees a phantom accept
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Datapath: operand capture, shift-add iteration and row down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_mag_in};
      mplier_q <= b_mag_in;
      cnt_q    <= CNT_LOAD;
      neg_q    <= a_neg_in ^ b_neg_in;
    end else if (state_q == S_CALC) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (!last_step) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Result register: loaded on the final row, held through and after DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
    end else if (last_step) begin
      product_q <= product_final;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: WIDTH=4 with and without signed
// support side by side on shared stimulus, plus a WIDTH=8 instance for edge
// operands and a reference-multiply sweep with random gaps and back-pressure.
module tb_seq_array_multiplier;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       sm;
  logic       out_ready;
  logic       in_ready_s, out_valid_s, busy_s;
  logic       in_ready_n, out_valid_n, busy_n;
  logic [7:0] product_s, product_n;

  logic       in_valid8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       sm8;
  logic       out_ready8;
  logic       in_ready8, out_valid8, busy8;
  logic [15:0] product8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_array_multiplier #(.WIDTH(4), .SIGNED_SUPPORT(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a4), .b(b4), .signed_mode(sm), .out_valid(out_valid_s),
    .out_ready(out_ready), .product(product_s), .busy(busy_s));

  seq_array_multiplier #(.WIDTH(4), .SIGNED_SUPPORT(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .a(a4), .b(b4), .signed_mode(sm), .out_valid(out_valid_n),
    .out_ready(out_ready), .product(product_n), .busy(busy_n));

  seq_array_multiplier #(.WIDTH(8), .SIGNED_SUPPORT(1'b1)) u_dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 transaction on both W4 instances; hold = DONE cycles with
  // out_ready low while the operand inputs are scrambled.
  task automatic mul4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                      input logic tsm, input logic [7:0] exp_s, input logic [7:0] exp_n,
                      input int hold);
    int edges;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready_s), 32'd1);
    a4 = ta; b4 = tb; sm = tsm; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a4 = 4'h0; b4 = 4'h0;
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 edges++;
      if (out_valid_s) break;
    end
    check({tag, " latency"}, 32'(edges), 32'd5);
    check({tag, " prod_s"}, 32'(product_s), 32'(exp_s));
    check({tag, " prod_n"}, 32'(product_n), 32'(exp_n));
    check({tag, " valid_n"}, 32'(out_valid_n), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); sm = 1'($urandom);
      @(posedge clk);
      #1;
      check({tag, " bp prod"}, 32'(product_s), 32'(exp_s));
      check({tag, " bp valid"}, 32'(out_valid_s), 32'd1);
      check({tag, " bp in_ready"}, 32'(in_ready_s), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " idle in_ready"}, 32'(in_ready_s), 32'd1);
    check({tag, " idle valid"}, 32'(out_valid_s), 32'd0);
    check({tag, " held prod"}, 32'(product_s), 32'(exp_s));
  endtask

  // One WIDTH=8 transaction with an idle gap before and a back-pressure hold after.
  task automatic mul8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tsm, input logic [15:0] exp, input int gap, input int hold);
    int edges;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready8), 32'd1);
    a8 = ta; b8 = tb; sm8 = tsm; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    edges = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 edges++;
      if (out_valid8) break;
    end
    check({tag, " latency"}, 32'(edges), 32'd9);
    check({tag, " prod"}, 32'(product8), 32'(exp));
    repeat (hold) @(posedge clk);
    #1 check({tag, " bp prod"}, 32'(product8), 32'(exp));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check({tag, " done"}, 32'(out_valid8), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic        rsm;
    logic [15:0] rexp;

    rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0; sm = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready_s), 32'd0);
    check("rst out_valid", 32'(out_valid_s), 32'd0);
    check("rst product", 32'(product_s), 32'd0);
    check("rst busy", 32'(busy_s), 32'd0);
    check("rst product8", 32'(product8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post rst in_ready", 32'(in_ready_s), 32'd1);

    mul4("u FxF",   4'hF, 4'hF, 1'b0, 8'hE1, 8'hE1, 0);
    mul4("s -8*-8", 4'h8, 4'h8, 1'b1, 8'h40, 8'h40, 0);
    mul4("s -8*7",  4'h8, 4'h7, 1'b1, 8'hC8, 8'h38, 0);
    mul4("s -1*1",  4'hF, 4'h1, 1'b1, 8'hFF, 8'h0F, 0);
    mul4("s 5*-3",  4'h5, 4'hD, 1'b1, 8'hF1, 8'h41, 0);
    mul4("s 0*-7",  4'h0, 4'h9, 1'b1, 8'h00, 8'h00, 0);
    mul4("s 7*7",   4'h7, 4'h7, 1'b1, 8'h31, 8'h31, 0);
    mul4("bp 6*9",  4'h6, 4'h9, 1'b0, 8'h36, 8'h36, 10);

    // Reset in the second CALC cycle abandons the computation
    @(negedge clk);
    a4 = 4'hE; b4 = 4'hE; sm = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(out_valid_s), 32'd0);
    check("midrst product", 32'(product_s), 32'd0);
    check("midrst busy", 32'(busy_s), 32'd0);
    check("midrst in_ready", 32'(in_ready_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst release", 32'(in_ready_s), 32'd1);
    repeat (6) @(posedge clk);
    #1 check("midrst no pulse", 32'(out_valid_s), 32'd0);
    mul4("after rst 3*5", 4'h3, 4'h5, 1'b0, 8'h0F, 8'h0F, 0);

    mul8("w8 0*x",     8'h00, 8'hA7, 1'b0, 16'h0000, 0, 0);
    mul8("w8 x*0",     8'h5C, 8'h00, 1'b1, 16'h0000, 1, 2);
    mul8("w8 FFxFF",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 0);
    mul8("w8 80x80 s", 8'h80, 8'h80, 1'b1, 16'h4000, 2, 1);
    mul8("w8 -1*-1",   8'hFF, 8'hFF, 1'b1, 16'h0001, 0, 0);
    mul8("w8 127*-128", 8'h7F, 8'h80, 1'b1, 16'hC080, 0, 3);

    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rsm = (i >= 200);
      if (rsm) rexp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
      else     rexp = {8'h00, ra} * {8'h00, rb};
      mul8(rsm ? "w8 rnd s" : "w8 rnd u", ra, rb, rsm, rexp,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
